io_poll_reader: RTL and testbench

Bus-side initiator for status/data polled peripherals such as the timer. On a read request it selects the status word and samples bit 0 (ready). When ready is set it selects the data word, captures it and pulses `ack` so the peripheral clears ready. It then hands the word to the CPU datapath over a valid/ready handshake. A poll limit bounds the wait, and a direct mode skips polling for peripherals whose data word is always valid.

---
 rtl/io_pkg.sv | 28 ++
 rtl/io_poll_reader_if.sv | 30 +++
 rtl/io_poll_reader_down_counter.sv | 30 +++
 rtl/io_poll_reader.sv | 124 ++++++++++++
 tb/tb_io_poll_reader.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// Shared constants and state encoding for polled status/data peripherals.
//   STATUS_SEL / DATA_SEL : values of the peripheral word select
//   READY_BIT             : ready flag position within the status word
//   poll_state_t          : io_poll_reader state encoding
package io_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_POLL = 3'd1;
   localparam logic [2:0] ST_GAP  = 3'd2;
   localparam logic [2:0] ST_READ = 3'd3;
   localparam logic [2:0] ST_ACK  = 3'd4;
   localparam logic [2:0] ST_DONE = 3'd5;

   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      POLL = ST_POLL,
      GAP  = ST_GAP,
      READ = ST_READ,
      ACK  = ST_ACK,
      DONE = ST_DONE
   } poll_state_t;

   localparam logic STATUS_SEL = 1'b0;
   localparam logic DATA_SEL   = 1'b1;

   localparam int unsigned READY_BIT = 0;

endpackage

// File: rtl/io_poll_reader_if.sv
// Peripheral bus plus consumer handshake of io_poll_reader.
//   statusordata : word select toward the peripheral (0 status, 1 data)
//   ack          : one-cycle acknowledge toward the peripheral
//   din          : peripheral read word
//   dout         : captured data word toward the consumer
//   dout_valid   : dout holds an unconsumed word
//   dout_ready   : consumer accepts dout
// master = the reader, slave = peripheral/consumer side.
interface io_poll_reader_if #(
   parameter int unsigned DATA_W = 16
) ();

   logic              statusordata;
   logic              ack;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic              dout_ready;

   modport master (
      output statusordata, ack, dout, dout_valid,
      input  din, dout_ready
   );

   modport slave (
      input  statusordata, ack, dout, dout_valid,
      output din, dout_ready
   );

endinterface

// File: rtl/io_poll_reader_down_counter.sv
// Loadable down counter with zero flag; stops at zero.
//   load/load_val : load a new count (has priority over dec)
//   dec           : decrement when non-zero
//   zero_c        : count is zero (combinational from the count register)
module down_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero_c
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero_c = (cnt == '0);

endmodule

// File: rtl/io_poll_reader.sv
// Polling read initiator: polls the status word until ready (or a poll
// limit), reads and acks the data word, then offers it on valid/ready.
//   clk, rst_n   : clock, async active-low reset
//   start/direct : read request, direct = skip status polling
//   bus          : peripheral select/ack/din and dout valid/ready handshake
//   busy         : not idle
//   timeout_err  : one-cycle pulse when the poll limit is exhausted
module io_poll_reader
   import io_pkg::*;
#(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned POLL_GAP  = 4,
   parameter int unsigned MAX_POLLS = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              direct,
   io_poll_reader_if.master  bus,
   output logic              busy,
   output logic              timeout_err
);

   localparam int unsigned PCNT_W = $clog2(MAX_POLLS + 1);
   localparam int unsigned GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

   poll_state_t       state, nxt;
   logic [PCNT_W-1:0] poll_cnt;
   logic              poll_inc, poll_clr;
   logic              gap_load, gap_dec, gap_zero_c;
   logic              sel_d, ack_d, valid_d, busy_d, timeout_d;
   logic              ready_c;

   assign ready_c = bus.din[READY_BIT];

   // Gap timer between status polls.
   down_counter #(.W(GAP_W)) u_gap (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (gap_load),
      .load_val (GAP_W'(POLL_GAP - 1)),
      .dec      (gap_dec),
      .zero_c   (gap_zero_c)
   );

   // Next state and next registered output values.
   always_comb begin
      nxt       = state;
      poll_inc  = 1'b0;
      poll_clr  = 1'b0;
      gap_load  = 1'b0;
      gap_dec   = 1'b0;
      timeout_d = 1'b0;
      sel_d     = STATUS_SEL;
      ack_d     = 1'b0;
      valid_d   = 1'b0;
      busy_d    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               poll_clr = 1'b1;
               nxt      = direct ? READ : POLL;
            end
         end
         POLL: begin
            if (ready_c) begin
               nxt = READ;
            end else begin
               poll_inc = 1'b1;
               // This failed poll is the last one allowed.
               if (poll_cnt >= PCNT_W'(MAX_POLLS - 1)) begin
                  nxt       = IDLE;
                  timeout_d = 1'b1;
               end else begin
                  nxt      = GAP;
                  gap_load = 1'b1;
               end
            end
         end
         GAP: begin
            if (gap_zero_c) nxt = POLL;
            else            gap_dec = 1'b1;
         end
         READ:    nxt = ACK;
         ACK:     nxt = DONE;
         DONE:    if (bus.dout_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
      // Data select is held through DONE so a transaction never flips back
      // to the status word until it has returned to IDLE.
      if ((nxt == READ) || (nxt == ACK) || (nxt == DONE)) sel_d = DATA_SEL;
      ack_d   = (nxt == ACK);
      valid_d = (nxt == DONE);
      busy_d  = (nxt != IDLE);
   end

   // State, poll counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         poll_cnt         <= '0;
         bus.statusordata <= STATUS_SEL;
         bus.ack          <= 1'b0;
         bus.dout         <= '0;
         bus.dout_valid   <= 1'b0;
         busy             <= 1'b0;
         timeout_err      <= 1'b0;
      end else begin
         state            <= nxt;
         bus.statusordata <= sel_d;
         bus.ack          <= ack_d;
         bus.dout_valid   <= valid_d;
         busy             <= busy_d;
         timeout_err      <= timeout_d;
         if (poll_clr) begin
            poll_cnt <= '0;
         end else if (poll_inc && (poll_cnt != PCNT_W'(MAX_POLLS))) begin
            poll_cnt <= poll_cnt + PCNT_W'(1);
         end
         if (state == READ) bus.dout <= DATA_W'(bus.din);
      end
   end

endmodule

// File: tb/tb_io_poll_reader.sv
// Scoreboard bench for io_poll_reader: stimulus pushes expected words with
// their valid/ack cycles, a monitor pops on each consumed word.
`timescale 1ns/1ps
module tb_io_poll_reader;

   localparam int unsigned DATA_W = 16;

   typedef struct {
      logic [DATA_W-1:0] data;
      int                valid_cyc;
      int                ack_cyc;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // DUT A: default parameters
   logic              start_a = 1'b0, direct_a = 1'b0, dout_ready_a = 1'b1;
   logic              busy_a, to_a;
   logic              ready_a = 1'b0, set_ready = 1'b0;
   logic [DATA_W-1:0] data_a = '0;
   io_poll_reader_if #(.DATA_W(DATA_W)) bus_a ();

   // DUT B: short poll limit, ready never set
   logic start_b = 1'b0, direct_b = 1'b0;
   logic busy_b, to_b;
   io_poll_reader_if #(.DATA_W(DATA_W)) bus_b ();

   io_poll_reader #(.DATA_W(DATA_W), .POLL_GAP(4), .MAX_POLLS(255)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .direct(direct_a),
      .bus(bus_a), .busy(busy_a), .timeout_err(to_a));

   io_poll_reader #(.DATA_W(DATA_W), .POLL_GAP(4), .MAX_POLLS(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .direct(direct_b),
      .bus(bus_b), .busy(busy_b), .timeout_err(to_b));

   // Peripheral models: ready clears when acked
   assign bus_a.din        = bus_a.statusordata ? data_a : {{(DATA_W-1){1'b0}}, ready_a};
   assign bus_a.dout_ready = dout_ready_a;
   assign bus_b.din        = bus_b.statusordata ? 16'hDEAD : 16'h0000;
   assign bus_b.dout_ready = 1'b1;

   always @(posedge clk) begin
      if (bus_a.ack)      ready_a <= 1'b0;
      else if (set_ready) ready_a <= 1'b1;
   end

   exp_t sb[$];
   int   s_checks = 0, s_fails = 0, m_checks = 0, m_fails = 0;
   logic dir_chk = 1'b0;
   int   sel_bad = 0;
   int   to_n = 0, to_at = -1, ackb_n = 0, vb_n = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      s_checks++;
      if (act !== exp) begin
         s_fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic mcheck(input string name, input logic [31:0] act, input logic [31:0] exp);
      m_checks++;
      if (act !== exp) begin
         m_fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DATA_W-1:0] d, input int vc, input int ac);
      exp_t e;
      e.data = d; e.valid_cyc = vc; e.ack_cyc = ac;
      sb.push_back(e);
   endtask

   // Monitor A: consumes words and compares against the scoreboard
   initial begin
      exp_t e;
      int   ack_n = 0, ack_at = -1, vld_at = -1;
      logic prev_v = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            sb.delete();
            ack_n  = 0;
            prev_v = 1'b0;
         end else begin
            if (bus_a.ack) begin ack_n++; ack_at = cyc; end
            if (bus_a.dout_valid && !prev_v) vld_at = cyc;
            prev_v = bus_a.dout_valid;
            if (dir_chk && busy_a && (bus_a.statusordata == 1'b0)) sel_bad++;
            if (bus_a.dout_valid && dout_ready_a) begin
               if (sb.size() == 0) begin
                  mcheck("unexpected_word", 32'(bus_a.dout), 32'hFFFF_FFFF);
               end else begin
                  e = sb.pop_front();
                  mcheck("dout", 32'(bus_a.dout), 32'(e.data));
                  mcheck("valid_cycle", vld_at, e.valid_cyc);
                  mcheck("ack_cycle", ack_at, e.ack_cyc);
                  mcheck("ack_count", ack_n, 1);
                  ack_n = 0;
               end
            end
         end
      end
   end

   // Monitor B: timeout pulse, acks and valids
   initial begin
      forever begin
         @(negedge clk);
         if (to_b) begin to_n++; to_at = cyc; end
         if (bus_b.ack) ackb_n++;
         if (bus_b.dout_valid) vb_n++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int s, c;
      // Reset state
      tick(2);
      check("rst_statusordata", 32'(bus_a.statusordata), 0);
      check("rst_ack", 32'(bus_a.ack), 0);
      check("rst_dout", 32'(bus_a.dout), 0);
      check("rst_dout_valid", 32'(bus_a.dout_valid), 0);
      check("rst_busy", 32'(busy_a), 0);
      check("rst_timeout", 32'(to_a), 0);
      rst_n = 1'b1;
      tick(1);

      // Ready on first poll
      data_a = 16'h1234;
      set_ready = 1'b1; tick(1); set_ready = 1'b0;
      start_a = 1'b1; s = cyc; push(16'h1234, s + 4, s + 3);
      tick(1); start_a = 1'b0;
      tick(6);

      // Ready after three failed polls
      data_a = 16'hA5C3;
      start_a = 1'b1; s = cyc; push(16'hA5C3, s + 19, s + 18);
      tick(1); start_a = 1'b0;
      tick(11);
      set_ready = 1'b1; tick(1); set_ready = 1'b0;
      tick(10);

      // Direct mode
      data_a = 16'h00FF;
      dir_chk = 1'b1; direct_a = 1'b1; start_a = 1'b1; s = cyc;
      push(16'h00FF, s + 3, s + 2);
      tick(1); start_a = 1'b0; direct_a = 1'b0;
      tick(5);
      dir_chk = 1'b0;
      check("direct_sel_status_cycles", sel_bad, 0);

      // Consumer stalls in DONE, start pulses ignored
      data_a = 16'hBEEF;
      set_ready = 1'b1; tick(1); set_ready = 1'b0;
      dout_ready_a = 1'b0;
      start_a = 1'b1; s = cyc; push(16'hBEEF, s + 4, s + 3);
      tick(1); start_a = 1'b0;
      tick(3);
      for (int i = 0; i < 10; i++) begin
         check("hold_dout", 32'(bus_a.dout), 32'h0000_BEEF);
         check("hold_valid", 32'(bus_a.dout_valid), 1);
         start_a  = (i % 3 == 0);
         direct_a = (i == 3);
         tick(1);
      end
      data_a = 16'h5A5A; set_ready = 1'b1; dout_ready_a = 1'b1;
      start_a = 1'b1; direct_a = 1'b0; c = cyc;
      push(16'h5A5A, c + 5, c + 4);
      tick(1); set_ready = 1'b0;
      tick(1); start_a = 1'b0;
      tick(6);

      // Timeout on DUT B
      start_b = 1'b1; s = cyc;
      tick(1); start_b = 1'b0;
      tick(5);
      check("b_busy_last_poll", 32'(busy_b), 1);
      check("b_no_early_timeout", to_n, 0);
      tick(6);
      check("b_timeout_count", to_n, 1);
      check("b_timeout_cycle", to_at, s + 7);
      check("b_ack_count", ackb_n, 0);
      check("b_valid_count", vb_n, 0);
      check("b_busy_after", 32'(busy_b), 0);
      check("b_dout", 32'(bus_b.dout), 0);

      // Async reset during ACK
      data_a = 16'h7E57;
      set_ready = 1'b1; tick(1); set_ready = 1'b0;
      start_a = 1'b1; s = cyc; push(16'h7E57, s + 4, s + 3);
      tick(1); start_a = 1'b0;
      tick(2);
      check("ack_before_reset", 32'(bus_a.ack), 1);
      #2 rst_n = 1'b0;
      #1;
      check("areset_ack", 32'(bus_a.ack), 0);
      check("areset_busy", 32'(busy_a), 0);
      check("areset_valid", 32'(bus_a.dout_valid), 0);
      check("areset_dout", 32'(bus_a.dout), 0);
      check("areset_sel", 32'(bus_a.statusordata), 0);
      tick(1);
      rst_n = 1'b1;
      tick(1);
      check("sb_dropped_on_reset", sb.size(), 0);
      data_a = 16'h600D;
      set_ready = 1'b1; tick(1); set_ready = 1'b0;
      start_a = 1'b1; s = cyc; push(16'h600D, s + 4, s + 3);
      tick(1); start_a = 1'b0;
      tick(6);

      check("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", s_checks + m_checks, s_fails + m_fails);
      $finish;
   end

endmodule
